// File: rtl/approx_mult_pkg.sv
// Shared constants and types for the approximate signed multiplier pipeline.
package approx_mult_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  localparam int unsigned DEFAULT_WIDTH       = 8;
  localparam int unsigned DEFAULT_APPROX_BITS = 4;

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned STG_S1     = 0;
  localparam int unsigned STG_S2     = 1;
  localparam int unsigned STG_S3     = 2;

  typedef logic [NUM_STAGES-1:0] stage_valid_t;

endpackage

// File: rtl/approx_mult_pp_group.sv
// Generates WIDTH/2 partial-product rows of a against one half of b and sums them.
// The low half is unsigned; the high half carries b's sign bit as a negative-weight row.
module approx_mult_pp_group
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          SIGNED_TOP = 1'b0,
  parameter int unsigned DROP_BITS  = 0
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH/2-1:0] i_b,
  input  logic               i_approx,
  output logic [2*WIDTH-1:0] o_sum_c
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CSH  = (DROP_BITS > 0) ? DROP_BITS - 1 : 0;
  localparam logic [HALF-1:0] DROP_MASK = HALF'((64'd1 << DROP_BITS) - 64'd1);

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_comp;

  assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  // Half-LSB compensation re-centres the truncation error of the dropped rows.
  assign w_comp  = (DROP_BITS > 0) ? (w_a_ext << CSH) : '0;

  always_comb begin
    logic [PW-1:0] v_row;
    o_sum_c = '0;
    v_row   = '0;
    for (int unsigned i = 0; i < HALF; i++) begin
      v_row = i_b[i] ? (w_a_ext << i) : '0;
      if (i_approx && DROP_MASK[i]) begin
        v_row = '0;
      end
      if (SIGNED_TOP && (i == HALF - 1)) begin
        o_sum_c = o_sum_c - v_row;
      end else begin
        o_sum_c = o_sum_c + v_row;
      end
    end
    if (i_approx && (DROP_BITS > 0)) begin
      o_sum_c = o_sum_c + w_comp;
    end
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage valid/ready signed multiplier with per-transaction exact/approximate mode.
// Optional macro APPROX_MULT_DIFF_EN adds the err output (exact product minus result).
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned APPROX_BITS = DEFAULT_APPROX_BITS
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               out_mode
`ifdef APPROX_MULT_DIFF_EN
  ,
  output logic [2*WIDTH-1:0] err
`endif
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned PW   = 2 * WIDTH;

  stage_valid_t     r_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_mode;
  logic [PW-1:0]    r_s2_lo;
  logic [PW-1:0]    r_s2_hi;
  logic             r_s2_mode;
  logic [PW-1:0]    r_s3_sum;
  logic             r_s3_mode;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_adv3;
  logic             w_accept;
  logic             w_s1_approx;
  logic [PW-1:0]    w_lo_sum;
  logic [PW-1:0]    w_hi_sum;
  logic [PW-1:0]    w_final;

  // A stage advances when it is empty or its successor advances.
  always_comb begin
    w_adv3   = !r_valid[STG_S3] || out_ready;
    w_adv2   = !r_valid[STG_S2] || w_adv3;
    w_adv1   = !r_valid[STG_S1] || w_adv2;
    in_ready = resetn && w_adv1 && !clear;
    w_accept = in_valid && in_ready;
  end

  assign w_s1_approx = (r_s1_mode == MODE_APPROX);
  assign w_final     = r_s2_lo + (r_s2_hi << HALF);

  approx_mult_pp_group #(
    .WIDTH      (WIDTH),
    .SIGNED_TOP (1'b0),
    .DROP_BITS  (APPROX_BITS)
  ) u_pp_lo (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b[HALF-1:0]),
    .i_approx (w_s1_approx),
    .o_sum_c  (w_lo_sum)
  );

  approx_mult_pp_group #(
    .WIDTH      (WIDTH),
    .SIGNED_TOP (1'b1),
    .DROP_BITS  (0)
  ) u_pp_hi (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b[WIDTH-1:HALF]),
    .i_approx (1'b0),
    .o_sum_c  (w_hi_sum)
  );

  // Stage occupancy; clear empties the whole pipe at the next edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
    end else if (clear) begin
      r_valid <= '0;
    end else begin
      if (w_adv1) r_valid[STG_S1] <= w_accept;
      if (w_adv2) r_valid[STG_S2] <= r_valid[STG_S1];
      if (w_adv3) r_valid[STG_S3] <= r_valid[STG_S2];
    end
  end

  // Payload registers only load on a real transfer so a stalled result stays put.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_mode <= MODE_EXACT;
      r_s2_lo   <= '0;
      r_s2_hi   <= '0;
      r_s2_mode <= MODE_EXACT;
      r_s3_sum  <= '0;
      r_s3_mode <= MODE_EXACT;
    end else begin
      if (w_accept) begin
        r_s1_a    <= a;
        r_s1_b    <= b;
        r_s1_mode <= mode;
      end
      if (w_adv2 && r_valid[STG_S1]) begin
        r_s2_lo   <= w_lo_sum;
        r_s2_hi   <= w_hi_sum;
        r_s2_mode <= r_s1_mode;
      end
      if (w_adv3 && r_valid[STG_S2]) begin
        r_s3_sum  <= w_final;
        r_s3_mode <= r_s2_mode;
      end
    end
  end

  assign out_valid = r_valid[STG_S3];
  assign result    = r_s3_sum;
  assign out_mode  = r_s3_mode;

`ifdef APPROX_MULT_DIFF_EN
  localparam int unsigned   CSH      = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
  localparam logic [PW-1:0] LOW_MASK = PW'((64'd1 << APPROX_BITS) - 64'd1);

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_low;
  logic [PW-1:0] w_comp;
  logic [PW-1:0] w_err_s2;
  logic [PW-1:0] r_s2_err;
  logic [PW-1:0] r_s3_err;

  // Error = weight of the dropped low rows minus the compensation term.
  assign w_a_ext  = {{WIDTH{r_s1_a[WIDTH-1]}}, r_s1_a};
  assign w_b_low  = PW'(r_s1_b) & LOW_MASK;
  assign w_comp   = (APPROX_BITS > 0) ? (w_a_ext << CSH) : '0;
  assign w_err_s2 = w_s1_approx ? ((w_a_ext * w_b_low) - w_comp) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_err <= '0;
      r_s3_err <= '0;
    end else begin
      if (w_adv2 && r_valid[STG_S1]) r_s2_err <= w_err_s2;
      if (w_adv3 && r_valid[STG_S2]) r_s3_err <= r_s2_err;
    end
  end

  assign err = r_s3_err;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Randomized scoreboard bench for approx_mult_pipe (WIDTH=8, APPROX_BITS=4).
module tb_approx_mult_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned AB = 4;

  logic             clk;
  logic             resetn;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   result;
  logic             out_mode;
`ifdef APPROX_MULT_DIFF_EN
  logic [2*W-1:0]   err;
`endif

  approx_mult_pipe #(.WIDTH(W), .APPROX_BITS(AB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_mode  (out_mode)
`ifdef APPROX_MULT_DIFF_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    logic [2*W-1:0] res;
    logic           md;
    logic [2*W-1:0] dif;
    int             acc;
  } exp_t;

  exp_t           q[$];
  exp_t           e;
  int             n_tests = 0;
  int             n_fail  = 0;
  int             n_out   = 0;
  int             cyc     = 0;
  int             last_stall_cyc = -1;
  bit             prev_hold = 0;
  logic [2*W-1:0] hold_res;
  logic           hold_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact signed product, or a*floor16(b) + a*8 in approximate mode, all mod 2^16.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tm, input int c);
    exp_t r;
    int ia, ib, exact, bt, comp, res;
    ia    = int'($signed(ta));
    ib    = int'($signed(tb));
    exact = ia * ib;
    bt    = ib & ~((1 << AB) - 1);
    comp  = (AB > 0) ? ia * (1 << (AB - 1)) : 0;
    res   = tm ? (ia * bt + comp) : exact;
    r.res = 16'(res);
    r.md  = tm;
    r.dif = 16'(exact - res);
    r.acc = c;
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_out_mode", out_mode, 0);
      chk("rst_in_ready", in_ready, 0);
      q.delete();
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", result, hold_res);
        chk("hold_mode", out_mode, hold_mode);
      end
      if (!out_ready) last_stall_cyc = cyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          n_out++;
          chk("result", result, e.res);
          chk("out_mode", out_mode, e.md);
`ifdef APPROX_MULT_DIFF_EN
          chk("err", err, e.dif);
`endif
          if (e.acc > last_stall_cyc) chk("latency", cyc - e.acc, 3);
        end
      end
      if (clear) begin
        chk("clear_in_ready", in_ready, 0);
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back(model(a, b, mode, cyc));
      end
      prev_hold = out_valid && !out_ready && !clear;
      hold_res  = result;
      hold_mode = out_mode;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    mode     = tm;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input longint exp_res, input logic exp_md);
    bit found;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1;
        chk(tag, longint'($signed(result)), exp_res);
        chk({tag, "_mode"}, out_mode, exp_md);
      end
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
    step();
  endtask

  logic [W-1:0] bp_a[6];
  logic [W-1:0] bp_b[6];
  logic         bp_m[6];

  initial begin
    int  sent, n0;
    bit  stall_seen;
    resetn = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    step();

    // Corner products and the approximate example, each with an empty pipe.
    send(8'h80, 8'h80, 1'b0);
    wait_out("exact_min_min", 16384, 1'b0);
    send(8'h7f, 8'h80, 1'b0);
    wait_out("exact_max_min", -16256, 1'b0);
    send(8'd10, 8'd7, 1'b1);
`ifdef APPROX_MULT_DIFF_EN
    begin
      bit found;
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
        @(negedge clk);
        if (out_valid) begin
          found = 1;
          chk("approx_10x7", longint'($signed(result)), 80);
          chk("approx_10x7_mode", out_mode, 1);
          chk("approx_10x7_err", longint'($signed(err)), -10);
        end
      end
      if (!found) chk("approx_10x7_timeout", 0, 1);
      step();
    end
`else
    wait_out("approx_10x7", 80, 1'b1);
`endif

    // Backpressure: six back-to-back ops, consumer stalls for cycles 4..8.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 8'($urandom);
      bp_b[i] = 8'($urandom);
      bp_m[i] = 1'($urandom);
    end
    sent = 0; stall_seen = 0; n0 = n_out;
    for (int c = 0; c < 40 && !(sent == 6 && c > 9 && q.size() == 0); c++) begin
      in_valid  = (sent < 6);
      a         = bp_a[sent % 6];
      b         = bp_b[sent % 6];
      mode      = bp_m[sent % 6];
      out_ready = !(c >= 4 && c <= 8);
      @(negedge clk);
      if (in_valid && !in_ready && !stall_seen) begin
        stall_seen = 1;
        chk("bp_held", q.size(), 3);
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_stall_seen", stall_seen, 1);
    chk("bp_sent", sent, 6);
    chk("bp_out_count", n_out - n0, 6);

    // Clear with three ops in flight and a competing input.
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b1);
    send(8'd5, 8'd6, 1'b0);
    clear = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9; mode = 1'b0;
    step();
    clear = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("clr_no_out", out_valid, 0);
      step();
    end

    // Randomized traffic with occasional clears and corner operands.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      a         = (($urandom % 8) == 0) ? 8'h80 : 8'($urandom);
      b         = (($urandom % 8) == 0) ? 8'h80 : 8'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      clear     = ($urandom % 50) == 0;
      step();
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() != 0; k++) step();
    chk("drain", q.size(), 0);

    // Reset mid-stream while a result is being presented.
    send(8'd5, 8'd6, 1'b0);
    send(8'd7, 8'd8, 1'b1);
    step();
    resetn = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    step();
    step();
    resetn = 1'b1;
    step();
    send(8'd3, 8'hfc, 1'b0);
    wait_out("post_rst_first", -12, 1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("final_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
